// File: rtl/fft_result_reader.sv
// fft_result_reader: drains a finished FFT result from the two read ports of the
// work RAM and streams it out one complex word per beat on a valid/ready interface.
// Port A fetches even bins and port B fetches odd bins. Each fetched pair goes into
// a two-pair FIFO, and the FIFO then emits the A word followed by the B word.
// A fetch is issued only while FIFO pairs plus in-flight pairs < 2.
// Build option: define FFT_RES_BITREV_EN when the core leaves its results in
// bit-reversed order. The RAM is then addressed at bitrev(bin), and the stream still
// comes out in natural bin order.
module fft_result_reader #(
  parameter int IWL = 32,
  parameter int AWL = 5
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           i_START,
  output logic [AWL-1:0] o_RAM_A_ADDR,
  output logic [AWL-1:0] o_RAM_B_ADDR,
  input  logic [IWL-1:0] i_RAM_A_DATA,
  input  logic [IWL-1:0] i_RAM_B_DATA,
  output logic [IWL-1:0] o_DATA,
  output logic [AWL-1:0] o_INDEX,
  output logic           o_VALID,
  input  logic           i_READY,
  output logic           o_LAST,
  output logic           o_BUSY
);

  // Pair counter width: N = 2**AWL bins form N/2 pairs.
  localparam int PW = AWL - 1;
  localparam logic [PW-1:0]  LAST_PAIR = {PW{1'b1}};
  localparam logic [AWL-1:0] LAST_BIN  = {AWL{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [IWL-1:0] a;   // even bin
    logic [IWL-1:0] b;   // odd bin
  } pair_t;

  state_t          state, state_next;
  pair_t           fifo_mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      fifo_cnt;        // pairs held, including a half-drained head
  logic            inflight;        // a read was issued at the last enabled edge
  logic [PW-1:0]   pair_cnt;
  logic [PW-1:0]   pair_next;
  logic            fetch_done;
  logic            start_ok, fetch, capture, xfer, pop, last_xfer;

  // Map a natural bin index to the RAM location that holds it.
  function automatic logic [AWL-1:0] addr_map(input logic [AWL-1:0] k);
    logic [AWL-1:0] r;
`ifdef FFT_RES_BITREV_EN
    for (int i = 0; i < AWL; i++) r[i] = k[AWL-1-i];
`else
    r = k;
`endif
    return r;
  endfunction

  assign pair_next = pair_cnt + PW'(1);
  assign start_ok  = EN && (state == IDLE) && i_START;
  assign xfer      = EN && o_VALID && i_READY;
  assign last_xfer = xfer && (o_INDEX == LAST_BIN);
  // The odd bin is the second word of the head pair, so taking it frees the slot.
  assign pop       = xfer && o_INDEX[0];
  // RAM port EN is tied to EN, so a read still in flight waits for EN to return.
  assign capture   = EN && inflight;
  assign fetch     = EN && (state == RUN) && !fetch_done &&
                     (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2);

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments in clocked blocks give every register the
    // value it held before the edge, whatever order the statements are in.
    if (RST)     state <= IDLE;
    else if (EN) state <= state_next;
  end

  // Next-state logic. A start pulse seen in RUN, including the last-beat cycle, is dropped.
  always_comb begin
    // NOTE: the default comes first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start_ok)  state_next = RUN;
      RUN:     if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy flag, and the head word selected by the bin parity.
  always_comb begin
    o_BUSY  = (state == RUN);
    o_VALID = (fifo_cnt != 2'd0);
    o_LAST  = o_VALID && (o_INDEX == LAST_BIN);
    o_DATA  = '0;
    if (o_VALID) o_DATA = o_INDEX[0] ? fifo_mem[rd_ptr].b : fifo_mem[rd_ptr].a;
  end

  // Fetch sequencer. The addresses update together with the pair they name.
  // After the final pair they hold their last value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pair_cnt     <= '0;
      fetch_done   <= 1'b0;
      inflight     <= 1'b0;
      o_RAM_A_ADDR <= '0;
      o_RAM_B_ADDR <= '0;
    end else if (EN) begin
      inflight <= fetch;
      if (start_ok) begin
        pair_cnt     <= '0;
        fetch_done   <= 1'b0;
        o_RAM_A_ADDR <= addr_map(AWL'(0));
        o_RAM_B_ADDR <= addr_map(AWL'(1));
      end else if (fetch) begin
        if (pair_cnt == LAST_PAIR) begin
          fetch_done <= 1'b1;
        end else begin
          pair_cnt     <= pair_next;
          o_RAM_A_ADDR <= addr_map({pair_next, 1'b0});
          o_RAM_B_ADDR <= addr_map({pair_next, 1'b1});
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else if (EN) begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, capture} - {1'b0, pop};
    end
  end

  // FIFO storage captures the RAM read data one cycle after the address.
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; o_DATA is forced to zero while the FIFO is empty,
    // so stale entries are never visible.
    if (capture) fifo_mem[wr_ptr] <= {i_RAM_A_DATA, i_RAM_B_DATA};
  end

  // Output bin index. It wraps from N-1 back to 0 as the unload completes.
  always_ff @(posedge CLK) begin
    if (RST)       o_INDEX <= '0;
    else if (xfer) o_INDEX <= o_INDEX + AWL'(1);
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed testbench for fft_result_reader, using IWL=32 and AWL=5.
// Expected RAM addressing follows FFT_RES_BITREV_EN when that macro is defined.
`timescale 1ns/1ps
module tb_fft_result_reader;

  logic        clk = 1'b0;
  logic        rst, en, i_start, i_ready;
  logic [4:0]  ram_a_addr, ram_b_addr, o_index;
  logic [31:0] ram_a_q, ram_b_q, o_data;
  logic        o_valid, o_last, o_busy;

  logic [31:0] ram [32];
  int          ram_mode;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fft_result_reader #(.IWL(32), .AWL(5)) dut (
    .CLK(clk), .RST(rst), .EN(en), .i_START(i_start),
    .o_RAM_A_ADDR(ram_a_addr), .o_RAM_B_ADDR(ram_b_addr),
    .i_RAM_A_DATA(ram_a_q), .i_RAM_B_DATA(ram_b_q),
    .o_DATA(o_data), .o_INDEX(o_index), .o_VALID(o_valid),
    .i_READY(i_ready), .o_LAST(o_last), .o_BUSY(o_busy)
  );

  // Registered dual-port RAM. Its enable is tied to the block enable.
  always @(posedge clk) begin
    if (en) begin
      ram_a_q <= ram[ram_a_addr];
      ram_b_q <= ram[ram_b_addr];
    end
  end

  function automatic logic [31:0] ram_word(input int mode, input int k);
    if (mode == 0) return 32'(k);
    return {16'(k * 7 + 3), 16'(16'hF0F0 ^ k)};
  endfunction

  function automatic logic [4:0] tb_addr(input int k);
    logic [4:0] v, r;
    v = 5'(k);
`ifdef FFT_RES_BITREV_EN
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
`else
    r = v;
`endif
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input int bin);
    return ram_word(ram_mode, int'(tb_addr(bin)));
  endfunction

  task automatic load_ram(input int mode);
    ram_mode = mode;
    for (int k = 0; k < 32; k++) ram[k] = ram_word(mode, k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; i_start = 1'b0; i_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++; if (o_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", o_last); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    checks++; if (o_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", o_data); end
    checks++; if (o_index !== 5'd0) begin failures++; $display("FAIL reset_index got=%0d want=0", o_index); end
    checks++; if (ram_a_addr !== 5'd0 || ram_b_addr !== 5'd0) begin
      failures++; $display("FAIL reset_addr got=%0d/%0d want=0/0", ram_a_addr, ram_b_addr); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL idle_hold valid=%b busy=%b want=0/0", o_valid, o_busy); end
  endtask

  // Full unload with i_READY held high: latency, first fetch addresses, back-to-back beats.
  task automatic test_stream();
    int beat;
    i_ready = 1'b1;
    pulse_start();
    checks++; if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      failures++; $display("FAIL start_e0 busy=%b valid=%b want=1/0", o_busy, o_valid); end
    checks++; if (ram_a_addr !== tb_addr(0) || ram_b_addr !== tb_addr(1)) begin
      failures++; $display("FAIL first_addr got=%0d/%0d want=%0d/%0d", ram_a_addr, ram_b_addr, tb_addr(0), tb_addr(1)); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL latency_e1 valid=%b want=0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL latency_e2 valid=%b want=1", o_valid); end
    beat = 0;
    for (int cyc = 0; cyc < 40 && beat < 32; cyc++) begin
      checks++;
      if (o_valid !== 1'b1) begin
        failures++; $display("FAIL stream_gap beat=%0d valid=%b want=1", beat, o_valid);
      end else begin
        if (o_index !== 5'(beat) || o_data !== exp_data(beat) || o_last !== (beat == 31)) begin
          failures++;
          $display("FAIL stream_beat beat=%0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                   beat, o_index, o_data, o_last, beat, exp_data(beat), beat == 31);
        end
        beat++;
      end
      tick();
    end
    checks++; if (beat != 32) begin failures++; $display("FAIL stream_count got=%0d want=32", beat); end
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      failures++; $display("FAIL stream_end busy=%b valid=%b want=0/0", o_busy, o_valid); end
  endtask

  // i_READY pattern 1,0,0,1: no loss or duplication, stable during stalls, FIFO bounded.
  task automatic test_backpressure();
    int beat;
    logic        stalled;
    logic [31:0] held_data;
    logic [4:0]  held_idx;
    logic        held_last;
    load_ram(1);
    i_ready = 1'b1;
    pulse_start();
    tick();
    beat = 0; stalled = 1'b0; held_data = '0; held_idx = '0; held_last = 1'b0;
    for (int cyc = 0; cyc < 200 && beat < 32; cyc++) begin
      i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (dut.fifo_cnt > 2'd2) begin
        checks++; failures++; $display("FAIL bp_fifo_depth pairs=%0d want<=2", dut.fifo_cnt);
      end
      if (stalled) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== held_data || o_index !== held_idx || o_last !== held_last) begin
          failures++;
          $display("FAIL bp_stable got v=%b idx=%0d data=%h last=%b want v=1 idx=%0d data=%h last=%b",
                   o_valid, o_index, o_data, o_last, held_idx, held_data, held_last);
        end
      end
      stalled = 1'b0;
      if (o_valid === 1'b1) begin
        checks++;
        if (o_index !== 5'(beat) || o_data !== exp_data(beat) || o_last !== (beat == 31)) begin
          failures++;
          $display("FAIL bp_beat beat=%0d got idx=%0d data=%h last=%b want idx=%0d data=%h",
                   beat, o_index, o_data, o_last, beat, exp_data(beat));
        end
        if (i_ready) beat++;
        else begin
          stalled = 1'b1; held_data = o_data; held_idx = o_index; held_last = o_last;
        end
      end
      tick();
    end
    i_ready = 1'b1;
    checks++; if (beat != 32) begin failures++; $display("FAIL bp_count got=%0d want=32", beat); end
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      failures++; $display("FAIL bp_end busy=%b valid=%b want=0/0", o_busy, o_valid); end
  endtask

  // i_START at beat 10 is ignored. i_START together with the last beat is dropped.
  task automatic test_start_ignored();
    int beat;
    load_ram(0);
    i_ready = 1'b1;
    pulse_start();
    tick();
    beat = 0;
    for (int cyc = 0; cyc < 60 && beat < 32; cyc++) begin
      i_start = (beat == 10 || beat == 31) && (o_valid === 1'b1);
      if (o_valid === 1'b1) begin
        checks++;
        if (o_index !== 5'(beat) || o_data !== exp_data(beat)) begin
          failures++;
          $display("FAIL si_beat beat=%0d got idx=%0d data=%h want idx=%0d data=%h",
                   beat, o_index, o_data, beat, exp_data(beat));
        end
        beat++;
      end
      tick();
    end
    i_start = 1'b0;
    checks++; if (beat != 32) begin failures++; $display("FAIL si_count got=%0d want=32", beat); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        failures++; $display("FAIL si_no_restart cyc=%0d valid=%b busy=%b want=0/0", i, o_valid, o_busy);
      end
      tick();
    end
  endtask

  // RST at beat 7 aborts at once. A new start then begins from bin 0.
  task automatic test_reset_mid();
    int beat;
    load_ram(0);
    i_ready = 1'b1;
    pulse_start();
    tick();
    beat = 0;
    for (int cyc = 0; cyc < 20 && beat < 7; cyc++) begin
      if (o_valid === 1'b1) beat++;
      tick();
    end
    checks++; if (o_index !== 5'd7) begin failures++; $display("FAIL rm_reach7 idx=%0d want=7", o_index); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_index !== 5'd0) begin
      failures++; $display("FAIL rm_abort valid=%b busy=%b idx=%0d want=0/0/0", o_valid, o_busy, o_index); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL rm_quiet cyc=%0d valid=%b want=0", i, o_valid); end
    end
    test_stream();
  endtask

  // EN low for 3 cycles starting the cycle after a fetch. The stream resumes intact.
  task automatic test_enable_stall();
    int          beat, stall_left;
    logic        stalled_once;
    logic [4:0]  prev_addr;
    logic        held_valid;
    load_ram(1);
    i_ready = 1'b1;
    pulse_start();
    tick();
    beat = 0; stall_left = 0; stalled_once = 1'b0; prev_addr = ram_a_addr; held_valid = 1'b0;
    for (int cyc = 0; cyc < 80 && beat < 32; cyc++) begin
      if (!stalled_once && beat >= 10 && ram_a_addr !== prev_addr) begin
        stall_left = 3; stalled_once = 1'b1; held_valid = o_valid;
      end
      prev_addr = ram_a_addr;
      if (stall_left > 0 && stall_left < 3) begin
        checks++;
        if (o_valid !== held_valid) begin
          failures++; $display("FAIL en_hold_valid got=%b want=%b", o_valid, held_valid);
        end
      end
      en = (stall_left == 0);
      if (o_valid === 1'b1) begin
        checks++;
        if (o_index !== 5'(beat) || o_data !== exp_data(beat)) begin
          failures++;
          $display("FAIL en_beat beat=%0d got idx=%0d data=%h want idx=%0d data=%h",
                   beat, o_index, o_data, beat, exp_data(beat));
        end
        if (en) beat++;
      end
      if (stall_left > 0) stall_left--;
      tick();
    end
    en = 1'b1;
    checks++; if (!stalled_once) begin failures++; $display("FAIL en_stall_applied got=0 want=1"); end
    checks++; if (beat != 32) begin failures++; $display("FAIL en_count got=%0d want=32", beat); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL en_end busy=%b want=0", o_busy); end
  endtask

  initial begin
    load_ram(0);
    test_reset();
    test_stream();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_enable_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
